branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage branch predictor with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It predicts direction and target for the current fetch PC. It is trained by the execute stage, which reports the resolved outcome (the `is_jump` decision) and predicted values carried down the pipe. Each update cycle it flags mispredictions and supplies the redirect PC, and it keeps branch and misprediction statistics.

## Interface
Parameters:
- ENTRIES, 16: BTB entries; power of two, ≥2; IDX = log2(ENTRIES)
- XLEN, 32: PC/target width

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- pc_f  in  XLEN  fetch PC
- pred_taken  out  1  predicted taken for pc_f
- pred_target  out  XLEN  predicted next PC for pc_f
- upd_valid  in  1  execute-stage instruction valid (not bubble/flushed)
- upd_pc  in  XLEN  PC of execute instruction
- upd_cti  in  1  instruction is B-type, JAL or JALR
- upd_uncond  in  1  instruction is JAL or JALR
- upd_taken  in  1  resolved taken (is_jump)
- upd_target  in  XLEN  resolved target
- upd_pred_taken  in  1  pred_taken carried from fetch
- upd_pred_target  in  XLEN  pred_target carried from fetch
- flush_all  in  1  invalidate whole BTB (fence.i)
- mispredict  out  1  execute instruction was mispredicted
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- stat_branches  out  32  resolved CTI count
- stat_misses  out  32  misprediction count

## Operation
- Entry: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:0], ctr[1:0]. Index = pc[IDX+1:2]; pc[1:0] ignored.
- Lookup, combinational on registered state: hit = valid && tag match. If hit && ctr[1]: pred_taken=1, pred_target=entry target. Otherwise pred_taken=0, pred_target=pc_f+4 (mod 2^XLEN).
- Resolution, combinational, qualified by upd_valid:
  - actual = upd_cti && upd_taken
  - next = actual ? upd_target : upd_pc+4
  - mispredict = upd_valid && (upd_pred_taken != actual || (actual && upd_pred_target != upd_target))
  - redirect_pc = next. Only meaningful when mispredict=1.
- Training, on clk when upd_valid=1, indexed by upd_pc:
  - CTI hit: ctr saturating +1 if taken, −1 if not (00↔11 bounds). When taken, target ← upd_target.
  - CTI miss, taken: allocate/replace. valid=1, tag, target. ctr=11 if upd_uncond, else 10.
  - CTI miss, not taken: no change.
  - Non-CTI hit (alias/stale entry): valid ← 0.
  - stat_branches +1 when upd_cti. stat_misses +1 when mispredict. Both wrap at 2^32.
- flush_all: all valid ← 0 on the next edge. It takes priority over a same-cycle training write; statistics still update.
- Lookup and training at the same index in the same cycle: lookup returns pre-update state (no bypass).

## Timing
- Reset (async assert, sync release by system): all valid=0, ctr=01, target=0, statistics=0. Hence pred_taken=0 and pred_target=pc_f+4.
- Prediction: zero-cycle combinational from pc_f.
- Mispredict/redirect_pc: same cycle as upd_valid, combinational.
- Table update visible to lookup from the cycle after the training edge.
- Reset asserted mid-operation clears all state immediately, regardless of clk. Pending updates are lost.
- No handshake; update accepted every cycle upd_valid=1 (throughput 1/cycle).

## Structure
- Shared package `bp_pkg`:
  - opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111, used by decode to drive upd_cti/upd_uncond
  - counter encodings SNT=00, WNT=01, WT=10, ST=11
  - entry struct/field widths
- One sub-module: `sat_ctr2`, combinational 2-bit saturating next-state (inc/dec), used in the training path.
- BTB arrays held in flops (reset required); no RAM macro.

## Test plan
- Reset, pc_f=0x100 → pred_taken=0, pred_target=0x104. Statistics 0.
- Update BEQ at 0x100, taken, target 0x80, pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle pc_f=0x100 → pred_taken=1, pred_target=0x80 (ctr=10).
- Same branch: not-taken twice → first update mispredict=1, redirect 0x104, ctr 10→01. Lookup pred_taken=0. Second update mispredict=0, ctr→00; further not-taken keeps 00.
- JAL at 0x200 target 0x400, then JALR at 0x200 target 0x500 with pred_target 0x400 → second update mispredict=1 (target mismatch), redirect 0x500. Entry target becomes 0x500.
- Aliasing (ENTRIES=16): 0x100 trained taken, then non-CTI at 0x100 with upd_pred_taken=1 → mispredict=1, redirect 0x104, entry invalidated. Tag mismatch at 0x140 → pred_taken=0.
- flush_all with a same-cycle taken update at 0x300 → no entry allocated, all lookups not-taken. stat_branches and stat_misses still increment. Async rst pulse mid-sequence → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: decode opcodes,
// 2-bit counter encodings and BTB entry field helpers.
package bp_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam int unsigned CTR_W = 2;

   typedef enum logic [CTR_W-1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   // Per-entry control bits; tag and target live in separate width-parameterised arrays.
   typedef struct packed {
      logic valid;
      ctr_e ctr;
   } btb_meta_t;

   function automatic int unsigned btb_tag_w(input int unsigned xlen, input int unsigned entries);
      return xlen - $clog2(entries) - 2;
   endfunction

   function automatic logic ctr_predicts_taken(input ctr_e c);
      return c[1];
   endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module sat_ctr2
   import bp_pkg::*;
(
   input  ctr_e ctr_i,
   input  logic inc_i,
   output ctr_e ctr_o
);

   // Step one state towards taken or not-taken, holding at either end.
   always_comb begin
      ctr_o = WNT;
      case (ctr_i)
         SNT:     ctr_o = inc_i ? WNT : SNT;
         WNT:     ctr_o = inc_i ? WT  : SNT;
         WT:      ctr_o = inc_i ? ST  : WNT;
         ST:      ctr_o = inc_i ? ST  : WT;
         default: ctr_o = WNT;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch prediction,
// execute-stage resolution/redirect, training and statistics counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_f,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_cti,
   input  logic            upd_uncond,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   input  logic            flush_all,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_misses
);

   localparam int unsigned IDX   = $clog2(ENTRIES);
   localparam int unsigned TAG_W = btb_tag_w(XLEN, ENTRIES);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   btb_meta_t        meta_q [ENTRIES];
   logic [TAG_W-1:0] tag_q  [ENTRIES];
   logic [XLEN-1:0]  tgt_q  [ENTRIES];
   logic [31:0]      stat_branches_q, stat_branches_d;
   logic [31:0]      stat_misses_q, stat_misses_d;

   logic [IDX-1:0]   f_idx_s, u_idx_s;
   logic             f_hit_s, u_hit_s, actual_s, wr_en_s;
   ctr_e             ctr_step_s;
   btb_meta_t        meta_d;
   logic [TAG_W-1:0] tag_d;
   logic [XLEN-1:0]  tgt_d;
   logic             unused_pc_lsbs_s;

   assign unused_pc_lsbs_s = ^{pc_f[1:0], upd_pc[1:0]};

   assign f_idx_s     = pc_f[IDX+1:2];
   assign f_hit_s     = meta_q[f_idx_s].valid && (tag_q[f_idx_s] == pc_f[XLEN-1:IDX+2]);
   assign pred_taken  = f_hit_s && ctr_predicts_taken(meta_q[f_idx_s].ctr);
   assign pred_target = pred_taken ? tgt_q[f_idx_s] : (pc_f + PC_STEP);

   assign actual_s    = upd_cti && upd_taken;
   assign redirect_pc = actual_s ? upd_target : (upd_pc + PC_STEP);
   assign mispredict  = upd_valid &&
                        ((upd_pred_taken != actual_s) || (actual_s && (upd_pred_target != upd_target)));

   assign u_idx_s = upd_pc[IDX+1:2];
   assign u_hit_s = meta_q[u_idx_s].valid && (tag_q[u_idx_s] == upd_pc[XLEN-1:IDX+2]);

   assign stat_branches = stat_branches_q;
   assign stat_misses   = stat_misses_q;

   sat_ctr2 u_sat_ctr2 (
      .ctr_i (meta_q[u_idx_s].ctr),
      .inc_i (upd_taken),
      .ctr_o (ctr_step_s)
   );

   // Training write for the single entry addressed by upd_pc.
   always_comb begin
      wr_en_s = 1'b0;
      meta_d  = meta_q[u_idx_s];
      tag_d   = tag_q[u_idx_s];
      tgt_d   = tgt_q[u_idx_s];
      if (upd_valid && upd_cti && u_hit_s) begin
         wr_en_s    = 1'b1;
         meta_d.ctr = ctr_step_s;
         if (upd_taken) begin
            tgt_d = upd_target;
         end else begin
            tgt_d = tgt_q[u_idx_s];
         end
      end else if (upd_valid && upd_cti && upd_taken) begin
         wr_en_s      = 1'b1;
         meta_d.valid = 1'b1;
         meta_d.ctr   = upd_uncond ? ST : WT;
         tag_d        = upd_pc[XLEN-1:IDX+2];
         tgt_d        = upd_target;
      end else if (upd_valid && !upd_cti && u_hit_s) begin
         // A non-CTI hitting an entry means the entry is stale or aliased.
         wr_en_s      = 1'b1;
         meta_d.valid = 1'b0;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Statistics next-state; counters wrap naturally at 2^32.
   always_comb begin
      if (upd_valid && upd_cti) begin
         stat_branches_d = stat_branches_q + 32'd1;
      end else begin
         stat_branches_d = stat_branches_q;
      end
      if (mispredict) begin
         stat_misses_d = stat_misses_q + 32'd1;
      end else begin
         stat_misses_d = stat_misses_q;
      end
   end

   // BTB and statistics state; a flush overrides any same-cycle training write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            meta_q[i] <= '{valid: 1'b0, ctr: WNT};
            tag_q[i]  <= '0;
            tgt_q[i]  <= '0;
         end
         stat_branches_q <= 32'd0;
         stat_misses_q   <= 32'd0;
      end else begin
         if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
               meta_q[i].valid <= 1'b0;
            end
         end else if (wr_en_s) begin
            meta_q[u_idx_s] <= meta_d;
            tag_q[u_idx_s]  <= tag_d;
            tgt_q[u_idx_s]  <= tgt_d;
         end
         stat_branches_q <= stat_branches_d;
         stat_misses_q   <= stat_misses_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_branch_predictor;

   localparam int ENT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_f, upd_pc, upd_target, upd_pred_target;
   logic        upd_valid, upd_cti, upd_uncond, upd_taken, upd_pred_taken, flush_all;
   logic        pred_taken, mispredict;
   logic [31:0] pred_target, redirect_pc, stat_branches, stat_misses;

   always #5 clk = ~clk;

   branch_predictor #(.ENTRIES(ENT), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .pc_f(pc_f),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cti(upd_cti),
      .upd_uncond(upd_uncond), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .flush_all(flush_all), .mispredict(mispredict), .redirect_pc(redirect_pc),
      .stat_branches(stat_branches), .stat_misses(stat_misses)
   );

   typedef struct {
      int          id;
      bit          pt;
      logic [31:0] ptgt;
      bit          mp;
      logic [31:0] rpc;
      logic [31:0] br;
      logic [31:0] ms;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_issued = 0;

   // Reference model: a table of entries addressed by word index, counters as plain integers.
   bit          m_valid [ENT];
   logic [31:0] m_tag   [ENT];
   logic [31:0] m_tgt   [ENT];
   int          m_ctr   [ENT];
   logic [31:0] m_br, m_ms;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % 32'(ENT));
   endfunction

   function automatic logic [31:0] mtag(input logic [31:0] pc);
      return pc / 32'(4 * ENT);
   endfunction

   function automatic bit mhit(input logic [31:0] pc);
      return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
      end
      m_br = 32'd0; m_ms = 32'd0;
   endtask

   task automatic model_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
      tk  = mhit(pc) && (m_ctr[midx(pc)] >= 2);
      tgt = tk ? m_tgt[midx(pc)] : pc + 32'd4;
   endtask

   task automatic model_train(input bit mp);
      int i;
      bit hit;
      if (upd_valid && upd_cti) m_br = m_br + 32'd1;
      if (mp) m_ms = m_ms + 32'd1;
      i   = midx(upd_pc);
      hit = mhit(upd_pc);
      if (flush_all) begin
         for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
      end else if (upd_valid && upd_cti && hit) begin
         if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = upd_target;
         end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (upd_valid && upd_cti && upd_taken) begin
         m_valid[i] = 1'b1; m_tag[i] = mtag(upd_pc); m_tgt[i] = upd_target;
         m_ctr[i]   = upd_uncond ? 3 : 2;
      end else if (upd_valid && !upd_cti && hit) begin
         m_valid[i] = 1'b0;
      end
   endtask

   // Compute this cycle's expectation from pre-update model state, queue it, then train.
   task automatic issue();
      exp_t e;
      bit   act;
      if (rst) model_reset();
      model_predict(pc_f, e.pt, e.ptgt);
      act   = upd_cti && upd_taken;
      e.rpc = act ? upd_target : upd_pc + 32'd4;
      e.mp  = upd_valid && ((upd_pred_taken != act) || (act && (upd_pred_target != upd_target)));
      e.br  = m_br;
      e.ms  = m_ms;
      e.id  = n_issued;
      n_issued++;
      sb.push_back(e);
      if (!rst) model_train(e.mp);
   endtask

   task automatic step(input logic [31:0] pcf, input bit v, input bit cti, input bit unc,
                       input bit tk, input logic [31:0] upc, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt, input bit fl);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pc_f = pcf; upd_valid = v; upd_cti = cti; upd_uncond = unc; upd_taken = tk;
      upd_pc = upc; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
      flush_all = fl;
      issue();
   endtask

   task automatic look(input logic [31:0] pcf);
      step(pcf, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
   endtask

   // Raise reset between edges so the monitor sees its effect before any clock edge.
   task automatic reset_pulse(input logic [31:0] pcf);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pc_f = pcf; upd_valid = 1'b0; upd_cti = 1'b0; upd_uncond = 1'b0; upd_taken = 1'b0;
      upd_pc = 32'd0; upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd4;
      flush_all = 1'b0;
      issue();
   endtask

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (txn %0d): got %h, expected %h", nm, id, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, compared half a period after it was issued.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("pred_taken",    e.id, {31'd0, pred_taken}, {31'd0, e.pt});
         chk("pred_target",   e.id, pred_target, e.ptgt);
         chk("mispredict",    e.id, {31'd0, mispredict}, {31'd0, e.mp});
         if (e.mp) chk("redirect_pc", e.id, redirect_pc, e.rpc);
         chk("stat_branches", e.id, stat_branches, e.br);
         chk("stat_misses",   e.id, stat_misses, e.ms);
      end
   end

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = 32'h100 + (32'($urandom_range(0, 47)) << 2);
      if ($urandom_range(0, 7) == 0) p = p + 32'($urandom_range(1, 3));
      return p;
   endfunction

   initial begin
      bit          v, cti, unc, tk, ptk, fl;
      logic [31:0] upc, tgt, ptgt;
      rst = 1'b1;
      pc_f = 32'h100; upd_valid = 1'b0; upd_cti = 1'b0; upd_uncond = 1'b0; upd_taken = 1'b0;
      upd_pc = 32'd0; upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
      flush_all = 1'b0;
      model_reset();
      reset_pulse(32'h100);

      step(32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0);
      look(32'h100);
      step(32'h100, 1, 1, 0, 0, 32'h100, 32'h0, 1, 32'h80, 0);
      step(32'h100, 1, 1, 0, 0, 32'h100, 32'h0, 0, 32'h104, 0);
      step(32'h100, 1, 1, 0, 0, 32'h100, 32'h0, 0, 32'h104, 0);
      look(32'h100);
      step(32'h200, 1, 1, 1, 1, 32'h200, 32'h400, 0, 32'h204, 0);
      step(32'h200, 1, 1, 1, 1, 32'h200, 32'h500, 1, 32'h400, 0);
      look(32'h200);
      step(32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0);
      step(32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0);
      step(32'h100, 1, 0, 0, 0, 32'h100, 32'h0, 1, 32'h80, 0);
      look(32'h140);
      look(32'h100);
      step(32'h200, 1, 1, 0, 1, 32'h300, 32'h600, 0, 32'h304, 1);
      look(32'h300);
      look(32'h200);
      step(32'h200, 1, 1, 1, 1, 32'h200, 32'h700, 0, 32'h204, 0);
      look(32'h200);
      reset_pulse(32'h200);
      look(32'h200);

      for (int n = 0; n < 600; n++) begin
         upc = rand_pc();
         v   = ($urandom_range(0, 9) != 0);
         cti = v && ($urandom_range(0, 3) != 0);
         unc = cti && ($urandom_range(0, 3) == 0);
         tk  = unc ? 1'b1 : ($urandom_range(0, 2) != 0);
         tgt = ($urandom_range(0, 1) == 0) ? rand_pc() : (32'($urandom) & 32'hFFFF_FFFC);
         if ($urandom_range(0, 1) == 0) begin
            model_predict(upc, ptk, ptgt);
         end else begin
            ptk  = $urandom_range(0, 1) != 0;
            ptgt = ptk ? tgt : upc + 32'd4;
         end
         fl = ($urandom_range(0, 49) == 0);
         step(rand_pc(), v, cti, unc, tk, upc, tgt, ptk, ptgt, fl);
      end
      look(32'h100);

      for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
